// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs, arbitrates exceptions, MRET and
// local interrupts, and issues one held fetch redirect per accepted event.
module trap_ctrl #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     NUM_IRQ     = 16,
   parameter logic [XLEN-1:0] RESET_MTVEC = '0,
   parameter bit              VECTORED_EN = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               exc_valid_i,
   input  logic [3:0]         exc_cause_i,
   input  logic [XLEN-1:0]    exc_pc_i,
   input  logic [XLEN-1:0]    exc_tval_i,
   input  logic [XLEN-1:0]    irq_pc_i,
   input  logic [NUM_IRQ-1:0] irq_lines_i,
   input  logic               mret_i,
   input  logic [11:0]        csr_addr_i,
   input  logic               csr_wen_i,
   input  logic [XLEN-1:0]    csr_wdata_i,
   output logic [XLEN-1:0]    csr_rdata_o,
   output logic               csr_hit_o,
   output logic               redirect_valid_o,
   output logic [XLEN-1:0]    redirect_pc_o,
   input  logic               redirect_ready_i
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REDIRECT = 1'b1} state_e;

   state_e              state_q, state_d;
   logic                redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
   logic                mie_q, mie_d, mpie_q, mpie_d;
   logic [NUM_IRQ-1:0]  mie_en_q, mie_en_d;
   logic [XLEN-3:0]     mtvec_base_q, mtvec_base_d;
   logic                mtvec_mode_q, mtvec_mode_d;
   logic [XLEN-1:0]     mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;

   logic [NUM_IRQ-1:0]  pending_s;
   logic [4:0]          irq_idx_s, irq_cause_s;
   logic                irq_any_s, event_s;
   logic [XLEN-1:0]     base_pc_s, irq_target_s, irq_mcause_s;

   // Interrupt pick: lowest-index pending line wins
   always_comb begin
      pending_s = irq_lines_i & mie_en_q & {NUM_IRQ{mie_q}};
      irq_any_s = |pending_s;
      irq_idx_s = 5'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         irq_idx_s = pending_s[i] ? 5'(i) : irq_idx_s;
      end
      irq_cause_s  = 5'd16 + irq_idx_s;
      irq_mcause_s = '0;
      irq_mcause_s[XLEN-1] = 1'b1;
      irq_mcause_s[4:0]    = irq_cause_s;
      base_pc_s    = {mtvec_base_q, 2'b00};
      irq_target_s = mtvec_mode_q ? (base_pc_s + (XLEN'(irq_cause_s) << 2)) : base_pc_s;
   end

   // CSR read mux and address decode
   always_comb begin
      csr_rdata_o = '0;
      csr_hit_o   = 1'b1;
      case (csr_addr_i)
         ADDR_MSTATUS: begin
            csr_rdata_o[12:11] = 2'b11;
            csr_rdata_o[7]     = mpie_q;
            csr_rdata_o[3]     = mie_q;
         end
         ADDR_MIE:    csr_rdata_o[16 +: NUM_IRQ] = mie_en_q;
         ADDR_MTVEC:  csr_rdata_o = {mtvec_base_q, 1'b0, mtvec_mode_q};
         ADDR_MEPC:   csr_rdata_o = mepc_q;
         ADDR_MCAUSE: csr_rdata_o = mcause_q;
         ADDR_MTVAL:  csr_rdata_o = mtval_q;
         ADDR_MIP:    csr_rdata_o[16 +: NUM_IRQ] = irq_lines_i;
         default:     csr_hit_o = 1'b0;
      endcase
   end

   // Next state: CSR writes first, then trap/MRET updates override the trap CSRs
   always_comb begin
      state_d          = state_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      mie_d            = mie_q;
      mpie_d           = mpie_q;
      mie_en_d         = mie_en_q;
      mtvec_base_d     = mtvec_base_q;
      mtvec_mode_d     = mtvec_mode_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      mtval_d          = mtval_q;
      event_s          = (state_q == ST_IDLE) && (exc_valid_i || mret_i || irq_any_s);

      if (csr_wen_i) begin
         case (csr_addr_i)
            ADDR_MIE: mie_en_d = csr_wdata_i[16 +: NUM_IRQ];
            ADDR_MTVEC: begin
               mtvec_base_d = csr_wdata_i[XLEN-1:2];
               mtvec_mode_d = csr_wdata_i[0] & VECTORED_EN;
            end
            ADDR_MSTATUS: begin
               if (!event_s) begin
                  mie_d  = csr_wdata_i[3];
                  mpie_d = csr_wdata_i[7];
               end else begin
                  mie_d  = mie_q;
               end
            end
            ADDR_MEPC:   mepc_d   = event_s ? mepc_q   : {csr_wdata_i[XLEN-1:2], 2'b00};
            ADDR_MCAUSE: mcause_d = event_s ? mcause_q : csr_wdata_i;
            ADDR_MTVAL:  mtval_d  = event_s ? mtval_q  : csr_wdata_i;
            default:     mie_en_d = mie_en_q;
         endcase
      end else begin
         mie_en_d = mie_en_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (exc_valid_i) begin
               mepc_d        = {exc_pc_i[XLEN-1:2], 2'b00};
               mcause_d      = XLEN'(exc_cause_i);
               mtval_d       = exc_tval_i;
               mpie_d        = mie_q;
               mie_d         = 1'b0;
               redirect_pc_d = base_pc_s;
            end else if (mret_i) begin
               mie_d         = mpie_q;
               mpie_d        = 1'b1;
               redirect_pc_d = mepc_q;
            end else if (irq_any_s) begin
               mepc_d        = {irq_pc_i[XLEN-1:2], 2'b00};
               mcause_d      = irq_mcause_s;
               mtval_d       = '0;
               mpie_d        = mie_q;
               mie_d         = 1'b0;
               redirect_pc_d = irq_target_s;
            end else begin
               redirect_pc_d = redirect_pc_q;
            end
            if (event_s) begin
               state_d          = ST_REDIRECT;
               redirect_valid_d = 1'b1;
            end else begin
               state_d          = ST_IDLE;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready_i) begin
               state_d          = ST_IDLE;
               redirect_valid_d = 1'b0;
            end else begin
               state_d          = ST_REDIRECT;
            end
         end
         default: begin
            state_d          = ST_IDLE;
            redirect_valid_d = 1'b0;
         end
      endcase
   end

   // State and CSR registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q          <= ST_IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         mie_q            <= 1'b0;
         mpie_q           <= 1'b0;
         mie_en_q         <= '0;
         mtvec_base_q     <= RESET_MTVEC[XLEN-1:2];
         mtvec_mode_q     <= RESET_MTVEC[0] & VECTORED_EN;
         mepc_q           <= '0;
         mcause_q         <= '0;
         mtval_q          <= '0;
      end else begin
         state_q          <= state_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         mie_q            <= mie_d;
         mpie_q           <= mpie_d;
         mie_en_q         <= mie_en_d;
         mtvec_base_q     <= mtvec_base_d;
         mtvec_mode_q     <= mtvec_mode_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         mtval_q          <= mtval_d;
      end
   end

   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap controller for the core, extending today's exception-only path with a parametrised set of local interrupts and vectored dispatch.
- Owns the trap CSRs and arbitrates exceptions against interrupts.
- On trap entry or MRET, issues one held redirect request to the fetch stage.
- Sits beside the CSR unit in the execute stage.

Parameters:
XLEN, 32, datapath and CSR width
NUM_IRQ, 16, local interrupt lines (1..16); line i has cause code 16+i
RESET_MTVEC, 'h0, mtvec value at reset
VECTORED_EN, 1, 1 = mtvec vectored mode supported; 0 = mode bit hardwired to 0

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
exc_valid  in  1  synchronous exception raised by the pipeline
exc_cause  in  4  exception code (2 = illegal instruction, etc.)
exc_pc  in  XLEN  PC of the faulting instruction
exc_tval  in  XLEN  trap value (faulting instruction bits or address)
irq_pc  in  XLEN  PC of the next unretired instruction; becomes mepc on an interrupt
irq_lines  in  NUM_IRQ  level-sensitive local interrupt requests
mret  in  1  MRET executing
csr_addr  in  12  CSR address
csr_wen  in  1  CSR write strobe
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  combinational read data (pre-write value)
csr_hit  out  1  csr_addr is owned by this block
redirect_valid  out  1  fetch redirect request
redirect_pc  out  XLEN  redirect target, stable while redirect_valid is high
redirect_ready  in  1  fetch accepts the redirect

Behaviour:
CSRs:
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] reads 2'b11, other bits read 0.
- mie 0x304: bits 16..16+NUM_IRQ-1 writable, other bits read 0.
- mtvec 0x305: base = wdata[XLEN-1:2]; mode = wdata[0] & VECTORED_EN; wdata[1] is ignored. Example: a write of 'h32 reads back 'h30.
- mepc 0x341: bits [1:0] forced to 0.
- mcause 0x342 and mtval 0x343: fully writable.
- mip 0x344: read-only, reflects irq_lines at bits 16+i; writes are ignored but csr_hit is still 1.

Reset (async):
- State IDLE, redirect_valid 0, redirect_pc 0.
- MIE = MPIE = 0, mie = 0, mtvec = RESET_MTVEC.
- mepc = mcause = mtval = 0.

State machine:
- Two states, IDLE and REDIRECT.
- IDLE -> REDIRECT on any accepted event: exception, interrupt or mret.
- REDIRECT -> IDLE in the cycle where redirect_ready is high.
- In REDIRECT, exc_valid, mret and interrupts are ignored; a bench assertion flags exc_valid or mret arriving in that state.

Arbitration in IDLE, highest priority first:
1. exc_valid.
2. mret.
3. Interrupt: pending = irq_lines & mie_bits & {NUM_IRQ{MIE}}; the lowest-index pending line wins.

Exception entry, at the edge after sampling:
- mepc = exc_pc, mcause = {0, cause}, mtval = exc_tval.
- MPIE = MIE, MIE = 0.
- redirect_pc = mtvec base.

Interrupt entry:
- mepc = irq_pc, mcause = {1, 16+i}, mtval = 0.
- MPIE = MIE, MIE = 0.
- redirect_pc = base in direct mode, or base + 4*(16+i) in vectored mode.

MRET:
- MIE = MPIE, MPIE = 1.
- redirect_pc = mepc.

Latency and handshake:
- An event sampled in cycle N gives updated CSRs and redirect_valid = 1 in cycle N+1.
- redirect_valid and redirect_pc hold until redirect_ready.
- If redirect_ready is already high at N+1, the block is back in IDLE at N+2.

Simultaneous CSR write and trap/MRET in the same cycle:
- The trap/MRET update wins for mstatus, mepc, mcause and mtval.
- Writes to mie and mtvec still apply; the redirect uses the pre-write mtvec.

Other boundaries:
- Reset asserted during REDIRECT drops redirect_valid immediately.
- An irq line deasserting before it is sampled causes no trap.

Test Plan:
1. Write mtvec 'h32 -> reads 'h30 (direct mode). Then exc_valid, cause 2, pc 'h14, tval 'hF11FD073 -> next cycle mcause = 2, mepc = 'h14, mtval = 'hF11FD073, redirect_pc = 'h30, MIE = 0.
2. mtvec = 'h101, mie bit 19 set, MIE = 1, irq_lines[3] = 1, irq_pc = 'h40 -> mcause = 'h80000013, mepc = 'h40, redirect_pc = 'h14C, MPIE = 1, MIE = 0.
3. Write mepc 'h3C, then mret with MPIE = 1 -> redirect_pc = 'h3C, MIE = 1, MPIE = 1.
4. exc_valid and an enabled irq in the same cycle -> exception taken (mcause MSB = 0). Irq_lines 'h5 with both lines enabled -> line 0 taken, mcause = 'h80000010.
5. MIE = 0 with irq pending -> no redirect; mip reads 'h10000 for irq_lines = 1. Hold redirect_ready = 0 for 5 cycles -> redirect_valid and redirect_pc stay stable.
6. Assert rst while in REDIRECT -> redirect_valid = 0 in the same cycle; all CSRs return to reset values.
